// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Collects the SIZE x SIZE result matrix of the systolic array once every PE
// has finished. The snapshot is then streamed out one word per valid/ready
// handshake in row-major order, so the array can start the next product
// while the results drain.
module systolic_result_drain #(
  parameter int SIZE     = 4,
  parameter int I_BITS   = 8,
  parameter int O_BITS   = (I_BITS * 2) + $clog2(SIZE),
  parameter int IDX_BITS = $clog2(SIZE * SIZE)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [SIZE*SIZE*O_BITS-1:0]   i_c_full,
  input  logic [SIZE*SIZE-1:0]          i_finish,
  output logic [O_BITS-1:0]             o_data,
  output logic [IDX_BITS-1:0]           o_index,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_overrun
);

  localparam int                  NUM_ELEM = SIZE * SIZE;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ELEM - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // One O_BITS word per element, element k at index k (k = row*SIZE+col).
  logic [NUM_ELEM-1:0][O_BITS-1:0] snap_q;
  logic [IDX_BITS-1:0]             idx_q;
  logic                            all_fin_d;

  logic all_fin;
  logic cap;
  logic handshake;
  logic at_last;
  logic load;
  logic advance;
  logic set_overrun;

  // Capture fires only on the rising edge of full completion; partial finish
  // patterns keep all_fin low and are ignored.
  assign all_fin   = &i_finish;
  assign cap       = all_fin & ~all_fin_d;
  assign at_last   = (idx_q == LAST_IDX);
  assign handshake = (state_q == DRAIN) & i_ready;

  // Outputs come from registers only; i_ready never reaches them combinationally.
  assign o_valid = (state_q == DRAIN);
  assign o_busy  = (state_q == DRAIN);
  assign o_last  = (state_q == DRAIN) & at_last;
  assign o_index = idx_q;
  assign o_data  = snap_q[idx_q];

  // Edge detector for full completion; reset to 0 so an already-complete
  // array right after reset still produces a capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) all_fin_d <= 1'b0;
    else         all_fin_d <= all_fin;
  end

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the load/advance/overrun strobes for the datapath.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    advance     = 1'b0;
    set_overrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake && !at_last) begin
          advance = 1'b1;
        end
        if (handshake && at_last) begin
          // A fresh result arriving exactly as the last word leaves is
          // taken back-to-back with no bubble.
          if (cap) load = 1'b1;
          else     state_d = IDLE;
        end
        if (cap && !(handshake && at_last)) begin
          // Snapshot is never touched mid-drain; the new result is dropped.
          set_overrun = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot register, loaded only at capture time.
  // NOTE: this wide register is reset because the idle/reset value of o_data
  // is defined as 0; a pure datapath store would normally be left unreset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)   snap_q <= '0;
    else if (load) snap_q <= i_c_full;
  end

  // Element index: cleared on capture, stepped on each non-final handshake.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)      idx_q <= '0;
    else if (load)    idx_q <= '0;
    else if (advance) idx_q <= idx_q + 1'b1;
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          o_overrun <= 1'b0;
    else if (set_overrun) o_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
// Directed scenario sequence with randomized data and ready patterns, checked
// every cycle against a queue-based reference model of the drain.
module tb_systolic_result_drain;

  localparam int SIZE     = 4;
  localparam int I_BITS   = 8;
  localparam int O_BITS   = (I_BITS * 2) + $clog2(SIZE);
  localparam int IDX_BITS = $clog2(SIZE * SIZE);
  localparam int N        = SIZE * SIZE;
  localparam logic [N-1:0] ALL_FIN = '1;

  logic                  clk;
  logic                  rst;
  logic [N*O_BITS-1:0]   c_full;
  logic [N-1:0]          finish;
  logic [O_BITS-1:0]     data;
  logic [IDX_BITS-1:0]   index;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic                  busy;
  logic                  overrun;

  systolic_result_drain #(
    .SIZE   (SIZE),
    .I_BITS (I_BITS)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_c_full  (c_full),
    .i_finish  (finish),
    .o_data    (data),
    .o_index   (index),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_last    (last),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the words still owed downstream, front = word on the bus.
  typedef struct {
    logic [O_BITS-1:0] word;
    int                k;
  } entry_t;

  entry_t q[$];
  bit     m_overrun;
  bit     m_prev_all;
  int     checks;
  int     errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*O_BITS-1:0] make_set(input int base, input bit rnd);
    logic [N*O_BITS-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*O_BITS +: O_BITS] = rnd ? O_BITS'($urandom) : O_BITS'(k + base);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_overrun  = 1'b0;
    m_prev_all = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, let the
  // model see the edge, then advance to 1 time unit past that edge.
  task automatic cycle(input bit rdy, input logic [N-1:0] fin);
    bit exp_valid;
    bit all_fin;
    bit cap;
    ready  = rdy;
    finish = fin;
    #1;
    exp_valid = (q.size() > 0);
    check("valid",   32'(valid),   32'(exp_valid));
    check("busy",    32'(busy),    32'(exp_valid));
    check("overrun", 32'(overrun), 32'(m_overrun));
    if (exp_valid) begin
      check("data",  32'(data),  32'(q[0].word));
      check("index", 32'(index), 32'(q[0].k));
      check("last",  32'(last),  32'(q[0].k == N - 1));
    end else begin
      check("last_idle", 32'(last), 32'(0));
    end
    all_fin    = &fin;
    cap        = all_fin && !m_prev_all;
    m_prev_all = all_fin;
    if (exp_valid && rdy) void'(q.pop_front());
    if (cap) begin
      if (q.size() == 0) begin
        for (int k = 0; k < N; k++) q.push_back('{c_full[k*O_BITS +: O_BITS], k});
      end else begin
        m_overrun = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Run cycles with all finish bits high until the word with index k is on
  // the bus; a run that never reaches it counts as a failed comparison.
  task automatic run_to_index(input int k);
    int guard = 0;
    while ((q.size() == 0 || q[0].k != k) && guard < 100) begin
      cycle(1'b1, ALL_FIN);
      guard++;
    end
    check("reach_index", 32'(guard < 100), 32'(1));
  endtask

  task automatic drain_all(input int mode, input logic [N-1:0] fin);
    int  guard = 0;
    bit  rdy;
    while (q.size() > 0 && guard < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 4 == 0) || (guard % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      cycle(rdy, fin);
      guard++;
    end
    check("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int first_valid;
    int n_valid;
    checks = 0;
    errors = 0;
    model_reset();
    ready  = 1'b0;
    finish = '0;
    c_full = '0;

    // Reset state, observed before any clock edge.
    rst = 1'b1;
    #2;
    check("rst_valid",   32'(valid),   32'(0));
    check("rst_last",    32'(last),    32'(0));
    check("rst_busy",    32'(busy),    32'(0));
    check("rst_data",    32'(data),    32'(0));
    check("rst_index",   32'(index),   32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic drain: finish rises at cycle 10, 16 consecutive words follow.
    c_full = make_set(100, 1'b0);
    for (int c = 0; c < 10; c++) cycle(1'b1, '0);
    first_valid = -1;
    n_valid     = 0;
    for (int c = 10; c < 30; c++) begin
      if (q.size() > 0) begin
        if (first_valid < 0) first_valid = c;
        n_valid++;
      end
      cycle(1'b1, ALL_FIN);
    end
    check("first_valid_cycle", 32'(first_valid), 32'(11));
    check("valid_cycles",      32'(n_valid),     32'(16));

    // Backpressure with ready pattern 1,0,0,1 on random data.
    cycle(1'b1, '0);
    c_full = make_set(0, 1'b1);
    cycle(1'b0, ALL_FIN);
    drain_all(1, ALL_FIN);

    // Partial finish for 50 cycles is ignored; the last bit triggers capture.
    c_full = make_set(0, 1'b1);
    for (int c = 0; c < 50; c++)
      cycle(1'($urandom), ALL_FIN & ~(N'(1) << $urandom_range(0, N - 1)));
    cycle(1'b1, ALL_FIN);
    check("partial_then_full", 32'(q.size()), 32'(N));
    drain_all(2, ALL_FIN);

    // Overrun: re-completion at index 5 is dropped, old words keep flowing.
    cycle(1'b1, '0);
    c_full = make_set(100, 1'b0);
    cycle(1'b1, ALL_FIN);
    run_to_index(4);
    cycle(1'b1, '0);
    c_full = make_set(200, 1'b0);
    cycle(1'b1, ALL_FIN);
    drain_all(0, ALL_FIN);
    cycle(1'b1, ALL_FIN);
    check("overrun_sticky", 32'(overrun), 32'(1));

    // Async reset mid-cycle at index 7 of a new drain.
    cycle(1'b1, '0);
    c_full = make_set(0, 1'b1);
    cycle(1'b1, ALL_FIN);
    run_to_index(7);
    finish = ALL_FIN;
    #2;
    rst = 1'b1;
    #1;
    check("async_valid",   32'(valid),   32'(0));
    check("async_busy",    32'(busy),    32'(0));
    check("async_overrun", 32'(overrun), 32'(0));
    check("async_last",    32'(last),    32'(0));
    model_reset();
    #1;
    rst = 1'b0;
    // Finish still high: first post-reset edge captures, word 0 follows.
    c_full = make_set(100, 1'b0);
    cycle(1'b1, ALL_FIN);
    check("post_reset_capture", 32'(q.size()), 32'(N));

    // Back-to-back: new completion coincides with the index-15 handshake.
    run_to_index(14);
    cycle(1'b1, '0);
    c_full = make_set(200, 1'b0);
    cycle(1'b1, ALL_FIN);
    check("b2b_valid",   32'(valid),   32'(1));
    check("b2b_index",   32'(index),   32'(0));
    check("b2b_data",    32'(data),    32'(200));
    check("b2b_overrun", 32'(overrun), 32'(0));
    drain_all(2, ALL_FIN);
    cycle(1'b1, ALL_FIN);
    cycle(1'b1, ALL_FIN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side collector for the SIZE×SIZE systolic matrix processor. It watches the array's per-PE finish flags and snapshots the full result bus once every PE has finished. It then streams the SIZE*SIZE results out one word per handshake, in row-major order, over a valid/ready interface. This frees the array to start the next product while results drain.

## Interface
- SIZE, 4, array dimension (rows = columns)
- I_BITS, 8, operand width of the array
- O_BITS, (I_BITS*2)+$clog2(SIZE), width of one result word
- IDX_BITS, $clog2(SIZE*SIZE), width of the element index

- i_clock  input  1  single clock; all state updates on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_c_full  input  SIZE*SIZE*O_BITS  array result bus; element k = bits [k*O_BITS +: O_BITS], k = row*SIZE+col
- i_finish  input  SIZE*SIZE  per-PE finish flags from the array, bit k for element k
- o_data  output  O_BITS  current result word
- o_index  output  IDX_BITS  element index k of o_data
- o_valid  output  1  o_data/o_index/o_last valid
- i_ready  input  1  downstream accepts word when o_valid && i_ready
- o_last  output  1  high with the final element (k = SIZE*SIZE-1)
- o_busy  output  1  high while a snapshot is held (state DRAIN)
- o_overrun  output  1  sticky: a new complete result arrived while draining and was dropped

## Operation
- all_fin = &i_finish; all_fin_d = all_fin registered; capture event cap = all_fin & ~all_fin_d (rising edge of full completion). Partial finish patterns are ignored.
- Snapshot register snap[SIZE*SIZE*O_BITS], index counter idx[IDX_BITS], 2-state FSM.
- IDLE: o_valid=0. On cap: snap <= i_c_full, idx <= 0, go DRAIN.
- DRAIN: o_valid=1, o_data = snap[idx*O_BITS +: O_BITS], o_index = idx, o_last = (idx == SIZE*SIZE-1).
  - Handshake (o_valid && i_ready) with o_last=0: idx <= idx+1.
  - Handshake with o_last=1 and no cap: go IDLE.
  - Handshake with o_last=1 and cap in the same cycle: snap <= i_c_full, idx <= 0, stay DRAIN. No bubble, no overrun.
  - cap without final handshake: snapshot unchanged, o_overrun <= 1.
  - No handshake: o_data, o_index, o_last held stable. Snapshot never changes mid-drain.
- o_busy = (state == DRAIN).
- o_overrun is cleared only by i_reset.
- Data is passed through unmodified. No width conversion and no sign handling.

## Timing
- Reset (async, immediate): state IDLE, idx 0, snap 0, all_fin_d 0, o_overrun 0.
- Output values during reset: o_valid 0, o_last 0, o_busy 0, o_data 0, o_index 0.
- Outputs are decoded from registers only; there is no combinational path from i_ready to o_valid or o_data.
- Capture latency:
  - all_fin goes high in cycle t (low in t-1).
  - snap is loaded at the end of t.
  - o_valid=1 with element 0 in cycle t+1.
- all_fin already high in the first cycle after reset counts as a rising edge (all_fin_d resets to 0).
- all_fin held high for many cycles produces exactly one capture. It must drop and rise again to produce another.
- Full drain with i_ready tied 1 takes SIZE*SIZE cycles: elements 0..SIZE*SIZE-1 are emitted on consecutive cycles.
- After the last handshake, o_valid is 0 in the next cycle unless a same-cycle cap occurred.
- Reset mid-drain aborts immediately. Remaining words are lost; o_valid drops asynchronously.

## Test plan
- SIZE=4, O_BITS=18, element k = k+100, i_ready=1. Raise all 16 finish bits at cycle 10 → o_valid from cycle 11 to 26; o_index 0..15; o_data 100..115; o_last only at index 15; o_busy 1 over the same span.
- Backpressure: toggle i_ready 1,0,0,1 repeating → o_data/o_index frozen on every i_ready=0 cycle; every element delivered exactly once, in order; no duplicates.
- Partial finish: 15 of 16 bits high for 50 cycles → o_valid stays 0. Set the 16th bit → element 0 appears the next cycle.
- Overrun: during a drain at index 5, drop then re-raise all finish bits with a new data set (k+200) → o_overrun=1 and stays 1; the remaining words still come from the old set (105..115); the state then returns to IDLE.
- Back-to-back: re-raise finish so that cap coincides with the index-15 handshake → next cycle o_valid=1, index 0, o_data=200; o_overrun stays 0.
- Async reset asserted mid-cycle at index 7 → o_valid, o_busy, o_overrun go 0 without waiting for a clock edge. After release with all_fin still high → a new capture begins and element 0 appears on the cycle after the first post-reset edge.
